calc_display: RTL

- Display-side receiver for the calculator's serial digit stream (status, data, pos).
- Captures the 8 decimal digits emitted one per cycle into a shadow buffer.
- Commits a completed frame atomically to a display buffer.
- Time-multiplexes the display buffer onto 8 seven-segment displays with active-low anode and segment drive.

---
 rtl/calc_disp_pkg.sv | 58 +++++
 rtl/calc_display_seg7_dec.sv | 15 +
 rtl/calc_display.sv | 134 +++++++++++++
 3 files changed

// File: rtl/calc_disp_pkg.sv
// Shared constants for the calculator display receiver: producer status codes,
// glyph codes and the active-low seven-segment table.
package calc_disp_pkg;

   typedef logic [3:0] digit_t;

   localparam logic [1:0] ST_ERRO    = 2'b00;
   localparam logic [1:0] ST_OCUPADO = 2'b01;
   localparam logic [1:0] ST_PRONTO  = 2'b10;
   localparam logic [1:0] ST_IMPRIME = 2'b11;

   localparam int unsigned DISP_DIGITS = 8;

   // Glyph codes share the 4-bit digit space; 0..9 are BCD digits.
   localparam digit_t DIG_BLANK = 4'hF;
   localparam digit_t GLY_E     = 4'hA;
   localparam digit_t GLY_R     = 4'hB;
   localparam digit_t GLY_O     = 4'hC;

   // Segment patterns {dp,g,f,e,d,c,b,a}, active-low, dp off.
   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_E     = 8'h86;
   localparam logic [7:0] SEG_R     = 8'hAF;
   localparam logic [7:0] SEG_O     = 8'hA3;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Glyph to segment pattern; unknown codes render blank.
   function automatic logic [7:0] seg_lookup(input digit_t glyph);
      logic [7:0] code;
      case (glyph)
         4'd0:    code = SEG_0;
         4'd1:    code = SEG_1;
         4'd2:    code = SEG_2;
         4'd3:    code = SEG_3;
         4'd4:    code = SEG_4;
         4'd5:    code = SEG_5;
         4'd6:    code = SEG_6;
         4'd7:    code = SEG_7;
         4'd8:    code = SEG_8;
         4'd9:    code = SEG_9;
         GLY_E:   code = SEG_E;
         GLY_R:   code = SEG_R;
         GLY_O:   code = SEG_O;
         default: code = SEG_BLANK;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/calc_display_seg7_dec.sv
// Combinational glyph/BCD to active-low seven-segment decoder with decimal point.
module seg7_dec
   import calc_disp_pkg::*;
(
   input  logic [3:0] glyph_i,
   input  logic       dp_i,
   output logic [7:0] seg_c_o
);

   // All table entries carry dp off (bit 7 high), so masking bit 7 lights it.
   always_comb begin
      seg_c_o = seg_lookup(digit_t'(glyph_i)) & {~dp_i, 7'h7F};
   end

endmodule

// File: rtl/calc_display.sv
// Display-side receiver: captures the serial digit stream into a shadow buffer,
// commits frames atomically and scans them onto 8 seven-segment displays.
// Optional leading-zero blanking is enabled by defining CALC_DISP_LZ_BLANK_EN.
module calc_display
   import calc_disp_pkg::*;
#(
   parameter int unsigned REFRESH_CYCLES = 100000,
   parameter int unsigned NUM_DIGITS     = DISP_DIGITS
)
(
   input  logic                  clock,
   input  logic                  reset,
   input  logic [1:0]            status,
   input  logic [3:0]            data,
   input  logic [3:0]            pos,
   output logic [NUM_DIGITS-1:0] an,
   output logic [7:0]            seg,
   output logic [7:0]            frame_cnt
);

   localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
   localparam int unsigned CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_CYCLES - 1);

   digit_t                shadow_q  [NUM_DIGITS];
   digit_t                shadow_d  [NUM_DIGITS];
   digit_t                display_q [NUM_DIGITS];
   digit_t                display_d [NUM_DIGITS];
   logic [1:0]            prev_q;
   logic [7:0]            frame_q,  frame_d;
   logic [CNT_W-1:0]      cnt_q,    cnt_d;
   logic [IDX_W-1:0]      idx_q,    idx_d;
   logic [NUM_DIGITS-1:0] an_q,     an_d;
   logic [7:0]            seg_q;
   logic [7:0]            seg_c;
   logic                  commit;
   logic                  wrap;
   digit_t                glyph;
   logic                  dp_on;

   // Capture valid printing-phase digits and commit when printing ends.
   always_comb begin
      shadow_d  = shadow_q;
      display_d = display_q;
      frame_d   = frame_q;
      commit    = (prev_q == ST_IMPRIME) && (status != ST_IMPRIME);
      if (status == ST_IMPRIME && pos >= 4'd1 && pos <= 4'(NUM_DIGITS) && data <= 4'd9)
         shadow_d[IDX_W'(pos - 4'd1)] = data;
      if (commit) begin
         display_d = shadow_q;
         frame_d   = frame_q + 8'd1;
      end
   end

   // Refresh timer and scan index.
   always_comb begin
      wrap  = (cnt_q == CNT_MAX);
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
      idx_d = wrap ? idx_q + IDX_W'(1) : idx_q;
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
   end

`ifdef CALC_DISP_LZ_BLANK_EN
   logic [NUM_DIGITS-1:0] lz_keep;
   logic                  seen_nz;

   // A slot renders only if a nonzero digit sits at or above it; slot 0 always renders.
   always_comb begin
      seen_nz = 1'b0;
      lz_keep = '0;
      for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
         if (display_q[i] != 4'd0 && display_q[i] <= 4'd9)
            seen_nz = 1'b1;
         lz_keep[i] = seen_nz || (i == 0);
      end
   end
`endif

   // Select what the scan-selected slot shows.
   always_comb begin
      glyph = display_q[idx_q];
      dp_on = 1'b0;
      if (status == ST_ERRO) begin
         case (idx_q)
            IDX_W'(3): glyph = GLY_E;
            IDX_W'(2): glyph = GLY_R;
            IDX_W'(1): glyph = GLY_R;
            IDX_W'(0): glyph = GLY_O;
            default:   glyph = DIG_BLANK;
         endcase
      end else begin
`ifdef CALC_DISP_LZ_BLANK_EN
         if (!lz_keep[idx_q])
            glyph = DIG_BLANK;
`endif
         dp_on = (status == ST_OCUPADO) && (idx_q == '0);
      end
   end

   seg7_dec u_seg7_dec (
      .glyph_i (glyph),
      .dp_i    (dp_on),
      .seg_c_o (seg_c)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            shadow_q[i]  <= DIG_BLANK;
            display_q[i] <= DIG_BLANK;
         end
         prev_q  <= ST_PRONTO;
         frame_q <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         an_q    <= '1;
         seg_q   <= SEG_BLANK;
      end else begin
         shadow_q  <= shadow_d;
         display_q <= display_d;
         prev_q    <= status;
         frame_q   <= frame_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         an_q      <= an_d;
         seg_q     <= seg_c;
      end
   end

   assign an        = an_q;
   assign seg       = seg_q;
   assign frame_cnt = frame_q;

endmodule
